// File: rtl/victim_writeback_ctrl_pkg.sv
// Shared cache package: victim writeback geometry, FSM state type and the
// line-buffer entry layout used by the FIFO and the burst controller.
package victim_writeback_ctrl_pkg;

  // Line-buffer depth and cache address geometry.
  localparam int SIZE          = 4;
  localparam int INDEX_WIDTH   = 6;
  localparam int TAG_WIDTH     = 20;
  localparam int LINE_WORD_NUM = 16;

  // Derived widths: beat counter, FIFO pointers, byte offset within a line.
  localparam int BEAT_WIDTH    = $clog2(LINE_WORD_NUM);
  localparam int PTR_WIDTH     = $clog2(SIZE);
  localparam int OFFSET_WIDTH  = BEAT_WIDTH + 2;

  // Writeback burst sequencing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wb_state_t;

  // One buffered victim line; data word 0 is sent first.
  typedef struct packed {
    logic                              valid;
    logic [TAG_WIDTH-1:0]              tag;
    logic [INDEX_WIDTH-1:0]            index;
    logic [LINE_WORD_NUM-1:0][31:0]    data;
  } victim_entry_t;

  // Line-aligned byte address of a victim line.
  function automatic logic [31:0] line_addr(input logic [TAG_WIDTH-1:0]   tag,
                                            input logic [INDEX_WIDTH-1:0] index);
    line_addr = {tag, index, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/victim_line_fifo.sv
// Circular line buffer holding evicted dirty lines until memory acknowledges
// them. Each entry carries its own valid bit, so full/empty fall out of the
// valid bits at the write/read pointers and no occupancy counter is kept.
// Every entry also compares itself against the lookup address so a refill
// can detect a line that has not yet reached memory.
module victim_line_fifo
  import victim_writeback_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  logic [TAG_WIDTH-1:0]           push_tag,
  input  logic [INDEX_WIDTH-1:0]         push_index,
  input  logic [LINE_WORD_NUM-1:0][31:0] push_data,
  input  logic                           pop,
  input  logic [TAG_WIDTH-1:0]           lkup_tag,
  input  logic [INDEX_WIDTH-1:0]         lkup_index,
  output logic                           full,
  output logic                           empty,
  output victim_entry_t                  head,
  output logic [SIZE-1:0]                match
);

  victim_entry_t          entries [SIZE];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic                   push_en;
  logic                   pop_en;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(SIZE - 1)) ptr_inc = '0;
    else                           ptr_inc = p + PTR_WIDTH'(1);
  endfunction

  // Valid bits at the pointers give full/empty; entries are contiguous
  // from rd_ptr up to wr_ptr-1.
  assign full    = entries[wr_ptr].valid;
  assign empty   = !entries[rd_ptr].valid;
  assign head    = entries[rd_ptr];

  // A push into a full buffer or a pop from an empty one is ignored, which
  // also guarantees push and pop never target the same slot in one cycle.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Entry storage and pointer update; push and pop may both happen in a cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SIZE; i++) entries[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop_en) begin
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= ptr_inc(rd_ptr);
      end
      if (push_en) begin
        entries[wr_ptr] <= '{valid: 1'b1, tag: push_tag, index: push_index, data: push_data};
        wr_ptr          <= ptr_inc(wr_ptr);
      end
    end
  end

  // Per-entry address compare; the in-flight head counts until it is popped.
  always_comb begin
    match = '0;
    for (int i = 0; i < SIZE; i++) begin
      match[i] = entries[i].valid &&
                 (entries[i].tag == lkup_tag) &&
                 (entries[i].index == lkup_index);
    end
  end

endmodule

// File: rtl/victim_writeback_ctrl.sv
// Victim writeback controller: buffers evicted dirty lines and drains them to
// memory one at a time as a single burst write (address, LINE_WORD_NUM data
// beats, response). The head line stays in the buffer, and visible to
// lookups, until the write response pops it.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both 1. Once raised, a valid (awvalid, wvalid, bready
// toward memory, and the owner's push_valid) is held with its payload stable
// until that transfer; ready may change freely and never depends on valid.
module victim_writeback_ctrl
  import victim_writeback_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push_valid,
  output logic                           push_ready,
  input  logic [TAG_WIDTH-1:0]           push_tag,
  input  logic [INDEX_WIDTH-1:0]         push_index,
  input  logic [LINE_WORD_NUM-1:0][31:0] push_data,
  input  logic [TAG_WIDTH-1:0]           lkup_tag,
  input  logic [INDEX_WIDTH-1:0]         lkup_index,
  output logic                           lkup_hit,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [31:0]                    awaddr,
  output logic [7:0]                     awlen,
  output logic                           wvalid,
  input  logic                           wready,
  output logic [31:0]                    wdata,
  output logic                           wlast,
  input  logic                           bvalid,
  output logic                           bready,
  output logic                           empty,
  output wb_state_t                      dbg_state
);

  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(LINE_WORD_NUM - 1);

  // The address layout must pack exactly into a 32-bit byte address and the
  // beat counter relies on a power-of-two line of at least two words.
  if (TAG_WIDTH + INDEX_WIDTH + BEAT_WIDTH + 2 != 32) begin : g_bad_addr_width
    $error("victim_writeback_ctrl: tag+index+offset widths must total 32");
  end
  if ((LINE_WORD_NUM < 2) || ((1 << BEAT_WIDTH) != LINE_WORD_NUM)) begin : g_bad_line_words
    $error("victim_writeback_ctrl: LINE_WORD_NUM must be a power of two >= 2");
  end

  wb_state_t              state;
  logic [BEAT_WIDTH-1:0]  beat;
  logic [BEAT_WIDTH-1:0]  beat_next;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  victim_entry_t          head;
  logic [SIZE-1:0]        match;

  // The buffer accepts only when a slot is free now; a pop this cycle frees
  // the slot for the next cycle, never the current one.
  assign push_ready = !fifo_full;
  assign fifo_push  = push_valid && push_ready;
  assign fifo_pop   = (state == ST_RESP) && bvalid;
  assign beat_next  = beat + BEAT_WIDTH'(1);

  assign lkup_hit   = |match;
  assign empty      = fifo_empty && (state == ST_IDLE);
  assign dbg_state  = state;

  victim_line_fifo u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (fifo_push),
    .push_tag   (push_tag),
    .push_index (push_index),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .lkup_tag   (lkup_tag),
    .lkup_index (lkup_index),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head),
    .match      (match)
  );

  // Burst sequencer with registered channel outputs; reset abandons any
  // burst in progress and drops every handshake signal immediately.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      beat    <= '0;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      wvalid  <= 1'b0;
      wdata   <= '0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state   <= ST_ADDR;
            awvalid <= 1'b1;
            awaddr  <= line_addr(head.tag, head.index);
            awlen   <= 8'(LINE_WORD_NUM - 1);
          end
        end
        ST_ADDR: begin
          if (awready) begin
            state   <= ST_DATA;
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= head.data[0];
            wlast   <= 1'b0;
            beat    <= '0;
          end
        end
        ST_DATA: begin
          if (wready) begin
            if (wlast) begin
              state  <= ST_RESP;
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              beat   <= '0;
              bready <= 1'b1;
            end else begin
              beat  <= beat_next;
              wdata <= head.data[beat_next];
              wlast <= (beat_next == LAST_BEAT);
            end
          end
        end
        ST_RESP: begin
          if (bvalid) begin
            state  <= ST_IDLE;
            bready <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_writeback_ctrl.sv
// Directed bench for victim_writeback_ctrl with a scoreboard of expected
// burst addresses and data words, checked by a channel monitor.
module tb_victim_writeback_ctrl;
  import victim_writeback_ctrl_pkg::*;

  logic                           clk = 1'b0;
  logic                           resetn = 1'b0;
  logic                           push_valid = 1'b0;
  logic                           push_ready;
  logic [TAG_WIDTH-1:0]           push_tag = '0;
  logic [INDEX_WIDTH-1:0]         push_index = '0;
  logic [LINE_WORD_NUM-1:0][31:0] push_data = '0;
  logic [TAG_WIDTH-1:0]           lkup_tag = '0;
  logic [INDEX_WIDTH-1:0]         lkup_index = '0;
  logic                           lkup_hit;
  logic                           awvalid;
  logic                           awready = 1'b0;
  logic [31:0]                    awaddr;
  logic [7:0]                     awlen;
  logic                           wvalid;
  logic                           wready = 1'b0;
  logic [31:0]                    wdata;
  logic                           wlast;
  logic                           bvalid = 1'b0;
  logic                           bready;
  logic                           empty;
  wb_state_t                      dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          mon_beat = 0;
  int          beats_seen = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  victim_writeback_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_tag   (push_tag),
    .push_index (push_index),
    .push_data  (push_data),
    .lkup_tag   (lkup_tag),
    .lkup_index (lkup_index),
    .lkup_hit   (lkup_hit),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wlast      (wlast),
    .bvalid     (bvalid),
    .bready     (bready),
    .empty      (empty),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel monitor: samples mid-cycle, pops the scoreboard on each handshake.
  task automatic monitor();
    logic        aw_stall = 1'b0;
    logic        w_stall = 1'b0;
    logic [31:0] aw_hold = '0;
    logic [31:0] w_hold = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_addr_q.delete();
        exp_q.delete();
        mon_beat = 0;
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall) begin
          chk("aw_hold_valid", 32'(awvalid), 32'd1);
          chk("aw_hold_addr", awaddr, aw_hold);
        end
        if (w_stall) begin
          chk("w_hold_valid", 32'(wvalid), 32'd1);
          chk("w_hold_data", wdata, w_hold);
        end
        aw_stall = awvalid && !awready;
        aw_hold  = awaddr;
        w_stall  = wvalid && !wready;
        w_hold   = wdata;
        if (awvalid && awready) begin
          chk("aw_expected", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) begin
            e = exp_addr_q.pop_front();
            chk("awaddr", awaddr, e);
            chk("awlen", 32'(awlen), 32'd15);
          end
        end
        if (wvalid && wready) begin
          chk("w_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wdata", wdata, e);
          end
          chk("wlast", 32'(wlast), 32'(mon_beat == 15));
          mon_beat   = (mon_beat + 1) % 16;
          beats_seen = beats_seen + 1;
        end
      end
    end
  endtask

  // Driver: offer one line, wait for acceptance, record expected burst.
  task automatic push_line(input logic [19:0] tag, input logic [5:0] idx, input logic [31:0] base);
    int guard = 0;
    push_valid = 1'b1;
    push_tag   = tag;
    push_index = idx;
    for (int i = 0; i < 16; i++) push_data[i] = base + 32'(i);
    while (!push_ready && guard < 300) begin
      tick();
      guard++;
    end
    chk("push_accept", 32'(push_ready), 32'd1);
    tick();
    push_valid = 1'b0;
    exp_addr_q.push_back({tag, idx, 6'b0});
    for (int i = 0; i < 16; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while (!(empty && exp_q.size() == 0 && exp_addr_q.size() == 0) && guard < 500) begin
      tick();
      guard++;
    end
    chk(tag, 32'(empty), 32'd1);
    chk({tag, "_queue"}, 32'(exp_q.size() + exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int guard;
    fork
      monitor();
    join_none

    // ---- reset values
    resetn = 1'b0;
    repeat (3) tick();
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_lkup_hit", 32'(lkup_hit), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_wlast", 32'(wlast), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_awlen", 32'(awlen), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    tick();

    // ---- single line, memory always ready
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    beats_seen = 0;
    push_line(20'h12345, 6'h05, 32'd0);
    guard = 0;
    while (!awvalid && guard < 20) begin tick(); guard++; end
    chk("t1_awaddr", awaddr, 32'h1234_5140);
    chk("t1_awlen", 32'(awlen), 32'd15);
    guard = 0;
    while (!(wvalid && wlast) && guard < 40) begin tick(); guard++; end
    chk("t1_last_wdata", wdata, 32'd15);
    chk("t1_empty_on_last", 32'(empty), 32'd0);
    tick();
    chk("t1_bready_resp", 32'(bready), 32'd1);
    chk("t1_empty_resp", 32'(empty), 32'd0);
    tick();
    chk("t1_empty_third", 32'(empty), 32'd1);
    chk("t1_beats", 32'(beats_seen), 32'd16);

    // ---- fill the buffer while the address channel stalls
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    push_line(20'h0000A, 6'h01, 32'h0000_0100);
    push_line(20'h0000B, 6'h02, 32'h0000_0200);
    push_line(20'h0000C, 6'h03, 32'h0000_0300);
    push_line(20'h0000C, 6'h03, 32'h0000_0400);
    chk("t2_full_ready", 32'(push_ready), 32'd0);
    push_valid = 1'b1; push_tag = 20'h0000D; push_index = 6'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_fifth_blocked", 32'(push_ready), 32'd0);
    end
    push_valid = 1'b0;
    awready = 1'b1;
    guard = 0;
    while (dbg_state != ST_RESP && guard < 60) begin tick(); guard++; end
    chk("t2_resp_state", 32'(dbg_state), 32'(ST_RESP));
    chk("t2_ready_before_pop", 32'(push_ready), 32'd0);
    bvalid = 1'b1;
    tick();
    chk("t2_ready_after_pop", 32'(push_ready), 32'd1);
    push_line(20'h0000E, 6'h07, 32'h0000_0500);
    wait_drain("t2_drain");

    // ---- data channel throttled every other cycle
    awready = 1'b1; bvalid = 1'b1; wready = 1'b0;
    beats_seen = 0;
    push_line(20'hABCDE, 6'h2A, 32'hC0DE_0000);
    guard = 0;
    while (!(empty && exp_q.size() == 0) && guard < 200) begin
      wready = ~wready;
      tick();
      guard++;
    end
    chk("t3_beats", 32'(beats_seen), 32'd16);
    chk("t3_empty", 32'(empty), 32'd1);
    wready = 1'b1;

    // ---- lookup against the in-flight head
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    lkup_tag = 20'h54321; lkup_index = 6'h11;
    push_line(20'h54321, 6'h11, 32'h1111_0000);
    guard = 0;
    while (dbg_state != ST_RESP && guard < 60) begin
      chk("t4_hit_flight", 32'(lkup_hit), 32'd1);
      tick();
      guard++;
    end
    chk("t4_hit_resp", 32'(lkup_hit), 32'd1);
    bvalid = 1'b1;
    tick();
    chk("t4_hit_after_pop", 32'(lkup_hit), 32'd0);
    lkup_index = 6'h10;
    push_line(20'h54321, 6'h11, 32'h2222_0000);
    guard = 0;
    while (!(empty && exp_q.size() == 0) && guard < 60) begin
      chk("t4_miss", 32'(lkup_hit), 32'd0);
      tick();
      guard++;
    end
    wait_drain("t4_drain");

    // ---- reset in the middle of a burst
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    lkup_tag = 20'h77777; lkup_index = 6'h3F;
    push_line(20'h77777, 6'h3F, 32'h5000_0000);
    guard = 0;
    while (!(wvalid && mon_beat == 7) && guard < 40) begin tick(); guard++; end
    chk("t5_at_beat7", wdata, 32'h5000_0007);
    resetn = 1'b0;
    tick();
    chk("t5_wvalid", 32'(wvalid), 32'd0);
    chk("t5_push_ready", 32'(push_ready), 32'd1);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_lkup_hit", 32'(lkup_hit), 32'd0);
    chk("t5_bready", 32'(bready), 32'd0);
    resetn = 1'b1;
    tick();
    beats_seen = 0;
    push_line(20'h0F0F0, 6'h22, 32'h6000_0000);
    wait_drain("t5_drain");
    chk("t5_beats", 32'(beats_seen), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/victim_writeback_ctrl.md
VICTIM_WRITEBACK_CTRL -- requirements
Module: victim_writeback_ctrl

Interface
REQ-001 Parameters SHALL be: SIZE=4 (line-buffer entries); INDEX_WIDTH=6; TAG_WIDTH=20; LINE_WORD_NUM=16 (32-bit words per line).
REQ-002 TAG_WIDTH+INDEX_WIDTH+log2(LINE_WORD_NUM)+2 SHALL equal 32; elaboration SHALL fail otherwise.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 push_valid  in  1  evicted dirty line offered.
REQ-006 push_ready  out  1  buffer can accept a line.
REQ-007 push_tag  in  TAG_WIDTH; push_index  in  INDEX_WIDTH; push_data  in  LINE_WORD_NUM x 32  line contents, word 0 first.
REQ-008 lkup_tag  in  TAG_WIDTH; lkup_index  in  INDEX_WIDTH  refill address under check.
REQ-009 lkup_hit  out  1  lookup matches a line not yet acknowledged by memory.
REQ-010 awvalid out 1; awready in 1; awaddr out 32; awlen out 8  burst write address channel.
REQ-011 wvalid out 1; wready in 1; wdata out 32; wlast out 1  write data channel.
REQ-012 bvalid in 1; bready out 1  write response channel.
REQ-013 empty  out  1  no line buffered or in flight.

Function
REQ-014 Buffer SHALL be a circular FIFO of SIZE entries {valid, tag, index, data}, 2-bit read/write pointers, wrap at SIZE.
REQ-015 push_ready SHALL be !full; a pop in the same cycle SHALL NOT raise push_ready (no full bypass).
REQ-016 Push SHALL occur when push_valid && push_ready; entry SHALL be drain-eligible the following cycle.
REQ-017 FSM states: IDLE, ADDR, DATA, RESP.
REQ-018 IDLE -> ADDR when FIFO non-empty; else stay.
REQ-019 ADDR: awvalid=1, awaddr={head.tag, head.index, offset zeros}, awlen=LINE_WORD_NUM-1; -> DATA on awready.
REQ-020 DATA: wvalid=1, wdata=head.data[beat]; beat (4-bit) SHALL increment only on wready; wlast=1 when beat==LINE_WORD_NUM-1; -> RESP on wready && wlast, beat cleared.
REQ-021 RESP: bready=1; on bvalid the head entry SHALL be popped (valid cleared, read pointer +1), -> IDLE.
REQ-022 awvalid/wvalid SHALL stay asserted with stable awaddr/wdata until the handshake completes.
REQ-023 lkup_hit SHALL be combinational: OR over valid entries of (tag==lkup_tag && index==lkup_index), including the in-flight head until its pop.
REQ-024 A push in the cycle of a pop SHALL both take effect; duplicate tag/index entries SHALL be allowed and drained in push order.
REQ-025 empty SHALL be 1 iff no valid entries and FSM in IDLE.

Reset
REQ-026 On resetn=0 at clk edge: all valid bits cleared, pointers and beat 0, FSM IDLE.
REQ-027 After reset: push_ready=1, lkup_hit=0, awvalid=0, wvalid=0, wlast=0, bready=0, empty=1, awaddr/wdata/awlen 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no further handshake assertion; memory-side recovery is outside this block.

Structure
REQ-029 Parameters, state enum and the entry struct typedef SHALL live in the shared cache package.
REQ-030 FIFO storage SHALL be the sub-module victim_line_fifo (push/pop/full/empty/head, per-entry tag compare outputs); FSM and beat counter SHALL stay in the top.

Verification
REQ-031 One push tag=0x12345, index=0x05, data[i]=i; awready/wready/bvalid always 1 -> awaddr=0x12345140, awlen=15, 16 beats 0..15, wlast on beat 15, empty=1 three cycles after last beat.
REQ-032 Four pushes with awready held 0 -> push_ready=0 after fourth; fifth push_valid not accepted; after awready=1 and first bvalid, push_ready=1 next cycle.
REQ-033 wready toggled 1/0 each cycle -> wdata stable while low, exactly 16 accepted beats, wlast only with beat 15.
REQ-034 Lookup tag/index of in-flight head -> lkup_hit=1 through RESP, 0 the cycle after bvalid pop; unmatched index -> 0 throughout.
REQ-035 resetn=0 at beat 7 -> next cycle wvalid=0, push_ready=1, empty=1, lkup_hit=0; subsequent push drains from beat 0.
